// File: rtl/pad_ctrl_pkg.sv
// Shared types and constants for the pad ownership controller.
package pad_ctrl_pkg;

  // Per-pad ownership state.
  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_OWN_A = 2'd1,
    PS_OWN_B = 2'd2,
    PS_TURN  = 2'd3
  } pad_state_e;

  // Width of the turnaround counter (TURN_CYC is limited to 0..15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/pad_slot_fsm.sv
// One pad's ownership FSM: round-robin arbitration between requesters A and B,
// a held (non-pre-emptable) grant, and a forced undriven gap after each release.
//
// Request/grant handshake: x_req is sampled on the rising clock edge; x_gnt is
// a registered level that rises one cycle after a winning x_req is sampled in
// IDLE and stays high for as long as x_req stays high. Dropping x_req is the
// only way to release. While x_gnt is high the pad OEN/I follow x_oen/x_out
// combinationally; the other requester's signals are ignored entirely.
module pad_slot_fsm
  import pad_ctrl_pkg::*;
#(
  parameter int TURN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_oen,
  input  logic       a_out,
  input  logic       b_req,
  input  logic       b_oen,
  input  logic       b_out,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic       pad_oen,
  output logic       pad_i,
  output pad_state_e state_o
);

  // Counter value loaded on release: the TURN state lasts TURN_CYC cycles.
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYC == 0) ? 0 : TURN_CYC - 1);

  pad_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last, last_n;   // last owner: 0 = A, 1 = B

  // State, turnaround counter and last-owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PS_IDLE;
      cnt   <= '0;
      last  <= 1'b1;                // B "was last" so A wins the first tie
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
    end
  end

  // Next-state logic: arbitration in IDLE, hold while owner requests, timed turnaround.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    case (state)
      PS_IDLE: begin
        if (a_req && (!b_req || last)) begin
          state_n = PS_OWN_A;
        end else if (b_req) begin
          state_n = PS_OWN_B;
        end
      end
      PS_OWN_A: begin
        if (!a_req) begin
          last_n = 1'b0;
          if (TURN_CYC == 0) begin
            state_n = PS_IDLE;
          end else begin
            state_n = PS_TURN;
            cnt_n   = TURN_LOAD;
          end
        end
      end
      PS_OWN_B: begin
        if (!b_req) begin
          last_n = 1'b1;
          if (TURN_CYC == 0) begin
            state_n = PS_IDLE;
          end else begin
            state_n = PS_TURN;
            cnt_n   = TURN_LOAD;
          end
        end
      end
      PS_TURN: begin
        // Requests stay pending here; they are only looked at again in IDLE.
        if (cnt == '0) begin
          state_n = PS_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = PS_IDLE;
    endcase
  end

  // Output decode from the registered state; owner's OEN/data pass straight through.
  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    pad_oen = 1'b1;
    pad_i   = 1'b0;
    case (state)
      PS_OWN_A: begin
        a_gnt   = 1'b1;
        pad_oen = a_oen;
        pad_i   = a_out;
      end
      PS_OWN_B: begin
        b_gnt   = 1'b1;
        pad_oen = b_oen;
        pad_i   = b_out;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: rtl/pad_share_ctrl.sv
// Pad ring ownership controller: one pad_slot_fsm per pad plus a shared
// 2-flop synchroniser on the asynchronous pad inputs.
module pad_share_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int NPADS    = 8,
  parameter int TURN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPADS-1:0]   a_req_i,
  input  logic [NPADS-1:0]   a_oen_i,
  input  logic [NPADS-1:0]   a_out_i,
  output logic [NPADS-1:0]   a_gnt_o,
  input  logic [NPADS-1:0]   b_req_i,
  input  logic [NPADS-1:0]   b_oen_i,
  input  logic [NPADS-1:0]   b_out_i,
  output logic [NPADS-1:0]   b_gnt_o,
  output logic [NPADS-1:0]   pad_in_o,
  output logic [NPADS-1:0]   pad_oen_o,
  output logic [NPADS-1:0]   pad_i_o,
  input  logic [NPADS-1:0]   pad_o_i,
  output logic [2*NPADS-1:0] dbg_state_o   // per-pad FSM state, 2 bits per pad
);

  logic [NPADS-1:0] sync1, sync2;

  // Two-flop synchroniser for pad_o_i, independent of pad ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_o_i;
      sync2 <= sync1;
    end
  end

  assign pad_in_o = sync2;

  for (genvar n = 0; n < NPADS; n++) begin : g_slot
    pad_state_e slot_state;

    pad_slot_fsm #(
      .TURN_CYC(TURN_CYC)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .a_req  (a_req_i[n]),
      .a_oen  (a_oen_i[n]),
      .a_out  (a_out_i[n]),
      .b_req  (b_req_i[n]),
      .b_oen  (b_oen_i[n]),
      .b_out  (b_out_i[n]),
      .a_gnt  (a_gnt_o[n]),
      .b_gnt  (b_gnt_o[n]),
      .pad_oen(pad_oen_o[n]),
      .pad_i  (pad_i_o[n]),
      .state_o(slot_state)
    );

    assign dbg_state_o[2*n +: 2] = slot_state;
  end

endmodule

// File: tb/tb_pad_share_ctrl.sv
// Bench for pad_share_ctrl: two instances (TURN_CYC=2 and TURN_CYC=0) share
// one set of inputs and are compared against an edge-based ownership model.
module tb_pad_share_ctrl;

  localparam int NP = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NP-1:0]   a_req = '0, a_oen = '1, a_out = '0;
  logic [NP-1:0]   b_req = '0, b_oen = '1, b_out = '0;
  logic [NP-1:0]   pad_o = '0;
  logic [NP-1:0]   a_gnt[2], b_gnt[2], pad_in[2], pad_oen[2], pad_i[2];
  logic [2*NP-1:0] dbg[2];

  pad_share_ctrl #(.NPADS(NP), .TURN_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_oen_i(a_oen), .a_out_i(a_out), .a_gnt_o(a_gnt[0]),
    .b_req_i(b_req), .b_oen_i(b_oen), .b_out_i(b_out), .b_gnt_o(b_gnt[0]),
    .pad_in_o(pad_in[0]), .pad_oen_o(pad_oen[0]), .pad_i_o(pad_i[0]),
    .pad_o_i(pad_o), .dbg_state_o(dbg[0])
  );

  pad_share_ctrl #(.NPADS(NP), .TURN_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req_i(a_req), .a_oen_i(a_oen), .a_out_i(a_out), .a_gnt_o(a_gnt[1]),
    .b_req_i(b_req), .b_oen_i(b_oen), .b_out_i(b_out), .b_gnt_o(b_gnt[1]),
    .pad_in_o(pad_in[1]), .pad_oen_o(pad_oen[1]), .pad_i_o(pad_i[1]),
    .pad_o_i(pad_o), .dbg_state_o(dbg[1])
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Per pad: who owns it (0 none, 1 A, 2 B), who owned it last, and the first
  // edge number at which it may be arbitrated again after a release.
  int            m_owner[2][NP];
  int            m_last[2][NP];
  int            m_next[2][NP];
  logic [NP-1:0] m_s1[2], m_s2[2];
  int            edge_n = 0;

  function automatic int turn_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Apply one clock edge to the model using the currently applied inputs.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (rst) begin
          m_owner[i][p] = 0;
          m_last[i][p]  = 2;
          m_next[i][p]  = 0;
        end else if (m_owner[i][p] == 1 && !a_req[p]) begin
          m_last[i][p]  = 1;
          m_owner[i][p] = 0;
          m_next[i][p]  = edge_n + turn_of(i) + 1;
        end else if (m_owner[i][p] == 2 && !b_req[p]) begin
          m_last[i][p]  = 2;
          m_owner[i][p] = 0;
          m_next[i][p]  = edge_n + turn_of(i) + 1;
        end else if (m_owner[i][p] == 0 && edge_n >= m_next[i][p]) begin
          if (a_req[p] && b_req[p]) m_owner[i][p] = (m_last[i][p] == 2) ? 1 : 2;
          else if (a_req[p])        m_owner[i][p] = 1;
          else if (b_req[p])        m_owner[i][p] = 2;
        end
      end
      if (rst) begin
        m_s1[i] = '0;
        m_s2[i] = '0;
      end else begin
        m_s2[i] = m_s1[i];
        m_s1[i] = pad_o;
      end
    end
    edge_n++;
  endtask

  // Expected outputs of instance i given model state and current inputs.
  task automatic model_exp(input int i, output logic [NP-1:0] ag, output logic [NP-1:0] bg,
                           output logic [NP-1:0] oe, output logic [NP-1:0] pi,
                           output logic [NP-1:0] pin);
    for (int p = 0; p < NP; p++) begin
      ag[p] = (m_owner[i][p] == 1);
      bg[p] = (m_owner[i][p] == 2);
      oe[p] = (m_owner[i][p] == 1) ? a_oen[p] : (m_owner[i][p] == 2) ? b_oen[p] : 1'b1;
      pi[p] = (m_owner[i][p] == 1) ? a_out[p] : (m_owner[i][p] == 2) ? b_out[p] : 1'b0;
    end
    pin = m_s2[i];
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change only #1 after the edge, outputs settle by then.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic flush();
    a_req = '0;
    b_req = '0;
    repeat (4) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst   = 1'b1;
    pad_o = 8'hFF;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pad_oen[i] !== 8'hFF) begin
        failures++;
        $display("FAIL reset_oen inst%0d got=%h exp=ff", i, pad_oen[i]);
      end
      checks++;
      if ((a_gnt[i] | b_gnt[i] | pad_i[i] | pad_in[i]) !== 8'h00) begin
        failures++;
        $display("FAIL reset_zero inst%0d gnt_a=%h gnt_b=%h pad_i=%h pad_in=%h exp=00",
                 i, a_gnt[i], b_gnt[i], pad_i[i], pad_in[i]);
      end
    end
    rst = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pad_in[i] !== 8'hFF) begin
        failures++;
        $display("FAIL reset_pad_in inst%0d got=%h exp=ff", i, pad_in[i]);
      end
    end
  endtask

  task automatic test_a_own();
    a_oen[3] = 1'b0;
    a_out[3] = 1'b1;
    a_req[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({a_gnt[0][3], pad_oen[0][3], pad_i[0][3]} !== 3'b101) begin
        failures++;
        $display("FAIL a_own_held cyc%0d got gnt/oen/i=%b%b%b exp=101",
                 c, a_gnt[0][3], pad_oen[0][3], pad_i[0][3]);
      end
    end
    a_req[3] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({a_gnt[0][3], pad_oen[0][3], pad_i[0][3]} !== 3'b010) begin
        failures++;
        $display("FAIL a_own_turn cyc%0d got gnt/oen/i=%b%b%b exp=010",
                 c, a_gnt[0][3], pad_oen[0][3], pad_i[0][3]);
      end
    end
    // Re-request now: the next edge only leaves TURN, the one after grants.
    a_req[3] = 1'b1;
    tick();
    checks++;
    if (a_gnt[0][3] !== 1'b0) begin
      failures++;
      $display("FAIL a_own_idle got=%b exp=0", a_gnt[0][3]);
    end
    tick();
    checks++;
    if (a_gnt[0][3] !== 1'b1) begin
      failures++;
      $display("FAIL a_own_regrant got=%b exp=1", a_gnt[0][3]);
    end
    a_oen[3] = 1'b1;
    a_out[3] = 1'b0;
    flush();
  endtask

  task automatic test_tie_gap();
    int first_b[2];
    first_b[0] = -1;
    first_b[1] = -1;
    a_req[0] = 1'b1;
    b_req[0] = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({a_gnt[i][0], b_gnt[i][0]} !== 2'b10) begin
        failures++;
        $display("FAIL tie_first inst%0d got a/b=%b%b exp=10", i, a_gnt[i][0], b_gnt[i][0]);
      end
    end
    tick();
    a_req[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (first_b[i] < 0 && b_gnt[i][0] === 1'b1) first_b[i] = k;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (first_b[i] - 1 !== turn_of(i) + 1) begin
        failures++;
        $display("FAIL tie_gap inst%0d got=%0d exp=%0d (-2 means never granted)",
                 i, first_b[i] - 1, turn_of(i) + 1);
      end
    end
    flush();
  endtask

  task automatic test_alternate();
    int winner;
    a_req[5] = 1'b1;
    b_req[5] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      winner = -1;
      for (int k = 0; k < 10 && winner < 0; k++) begin
        tick();
        if (a_gnt[0][5] === 1'b1)      winner = 0;
        else if (b_gnt[0][5] === 1'b1) winner = 1;
      end
      checks++;
      if (winner !== r % 2) begin
        failures++;
        $display("FAIL alternate round%0d got=%0d exp=%0d (0=A 1=B -1=none)", r, winner, r % 2);
      end
      if (winner == 0) a_req[5] = 1'b0;
      else             b_req[5] = 1'b0;
      tick();
      a_req[5] = 1'b1;
      b_req[5] = 1'b1;
    end
    flush();
  endtask

  task automatic test_nonowner();
    logic [2:0] oen_seq;
    oen_seq  = 3'b010;
    b_req[7] = 1'b1;
    b_oen[7] = 1'b0;
    b_out[7] = 1'b0;
    tick();
    a_req[7] = 1'b1;
    a_oen[7] = 1'b0;
    a_out[7] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      b_oen[7] = oen_seq[s];
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({b_gnt[i][7], a_gnt[i][7], pad_oen[i][7], pad_i[i][7]} !== {2'b10, oen_seq[s], 1'b0}) begin
          failures++;
          $display("FAIL nonowner inst%0d step%0d got gnt_b/gnt_a/oen/i=%b%b%b%b exp=10%b0",
                   i, s, b_gnt[i][7], a_gnt[i][7], pad_oen[i][7], pad_i[i][7], oen_seq[s]);
        end
      end
    end
    b_oen[7] = 1'b1;
    a_oen[7] = 1'b1;
    a_out[7] = 1'b0;
    flush();
  endtask

  task automatic test_reset_mid();
    a_req[2] = 1'b1;
    a_oen[2] = 1'b0;
    tick();
    checks++;
    if (a_gnt[0][2] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_own got=%b exp=1", a_gnt[0][2]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({a_gnt[0][2], pad_oen[0][2]} !== 2'b01) begin
      failures++;
      $display("FAIL rst_mid_release got gnt/oen=%b%b exp=01", a_gnt[0][2], pad_oen[0][2]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({a_gnt[0][2], pad_oen[0][2]} !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid_no_turn got gnt/oen=%b%b exp=10", a_gnt[0][2], pad_oen[0][2]);
    end
    a_oen[2] = 1'b1;
    flush();
  endtask

  task automatic test_random();
    logic [NP-1:0] eag, ebg, eoe, epi, epin;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) a_req[p] = ~a_req[p];
        if ($urandom_range(0, 3) == 0) b_req[p] = ~b_req[p];
      end
      a_oen = NP'($urandom);
      a_out = NP'($urandom);
      b_oen = NP'($urandom);
      b_out = NP'($urandom);
      pad_o = NP'($urandom);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        model_exp(i, eag, ebg, eoe, epi, epin);
        checks++;
        if (a_gnt[i] !== eag) begin
          failures++;
          $display("FAIL rand_a_gnt inst%0d cyc%0d got=%h exp=%h", i, c, a_gnt[i], eag);
        end
        checks++;
        if (b_gnt[i] !== ebg) begin
          failures++;
          $display("FAIL rand_b_gnt inst%0d cyc%0d got=%h exp=%h", i, c, b_gnt[i], ebg);
        end
        checks++;
        if (pad_oen[i] !== eoe) begin
          failures++;
          $display("FAIL rand_pad_oen inst%0d cyc%0d got=%h exp=%h", i, c, pad_oen[i], eoe);
        end
        checks++;
        if (pad_i[i] !== epi) begin
          failures++;
          $display("FAIL rand_pad_i inst%0d cyc%0d got=%h exp=%h", i, c, pad_i[i], epi);
        end
        checks++;
        if (pad_in[i] !== epin) begin
          failures++;
          $display("FAIL rand_pad_in inst%0d cyc%0d got=%h exp=%h", i, c, pad_in[i], epin);
        end
      end
    end
    rst = 1'b0;
    flush();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_a_own();
    test_tie_gap();
    test_alternate();
    test_nonowner();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
